one_hot_mode_decoder: RTL
=========================

// Module: one_hot_mode_decoder
//
// PURPOSE
// Receive-side counterpart of the mode one-hot encoder: recovers a 2-bit mode code from
// the three one-hot select lines (select_1/2/3). Synchronises, qualifies (debounces) and
// validates the selects, then publishes a registered mode with an update pulse and a
// fault indication for illegal (zero-hot or multi-hot) patterns. Sits on the consumer
// side of the mode-select path, ahead of the datapath mode muxes.
//
// PARAMETERS
// STABLE_CYCLES  4  consecutive identical valid samples required to commit a mode (>=1)
// FAULT_CYCLES   8  consecutive invalid samples that raise fault (>=1)
// CNT_W          4  counter width; must hold max(STABLE_CYCLES, FAULT_CYCLES)
//
// PORTS
// clk          in   1  single clock, rising edge
// rst_n        in   1  asynchronous, active-low reset
// select_1     in   1  one-hot select, decodes to mode 2'b00
// select_2     in   1  one-hot select, decodes to mode 2'b10
// select_3     in   1  one-hot select, decodes to mode 2'b11
// fault_clr    in   1  one-cycle pulse, clears sticky fault_seen
// mode_out     out  2  committed mode code
// mode_valid   out  1  mode_out holds a qualified mode
// mode_update  out  1  one-cycle pulse when mode_out/mode_valid newly commit
// fault        out  1  level: currently in FAULT state
// fault_seen   out  1  sticky: FAULT entered since last fault_clr/reset
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state=INIT, mode_out=2'b00, mode_valid=0, mode_update=0,
//   fault=0, fault_seen=0, all counters and synchronisers cleared. Effective immediately,
//   also mid-qualification.
// - Selects pass a 2-flop synchroniser; all decisions use synchronised sample s[2:0].
// - Sample valid iff exactly one bit set; code: s1->00, s2->10, s3->11. Code 2'b01 never output.
// - inv_cnt: +1 per invalid sample (saturating), cleared on any valid sample.
//   inv_cnt reaching FAULT_CYCLES in INIT/LOCKED/QUAL -> FAULT.
// - States:
//   INIT   : valid sample -> QUAL, cand<=code, q_cnt<=1.
//   QUAL   : sample==cand -> q_cnt+1; on q_cnt reaching STABLE_CYCLES -> LOCKED, commit.
//            different valid code -> restart: cand<=code, q_cnt<=1.
//            invalid -> home state (LOCKED if mode_valid else INIT), q_cnt<=0.
//   LOCKED : sample==mode_out -> stay. Different valid code -> QUAL. Invalid -> counts.
//   FAULT  : fault=1, mode_valid=0, mode_out held. Valid sample -> QUAL; fault stays 1
//            until commit.
// - STABLE_CYCLES=1: first valid sample commits directly (QUAL transient).
// - Commit (registered): mode_out<=cand, mode_valid<=1, fault<=0; mode_update=1 for one
//   cycle only if cand!=mode_out or mode_valid was 0. Re-qualifying the current mode does
//   not pulse.
// - During QUAL mode_out/mode_valid keep previous values (no glitch to consumers).
// - Latency: select pins change and hold -> mode_update high exactly 2+STABLE_CYCLES
//   rising edges later.
// - FAULT entry: fault<=1, mode_valid<=0, fault_seen<=1 same edge; no mode_update.
// - fault_clr clears fault_seen next edge; simultaneous FAULT entry wins (stays 1).
//
// TESTING
// 1 reset, hold select_1 -> 6 edges later mode_out=00, mode_valid=1, one mode_update pulse.
// 2 from mode 00 switch to select_3 -> mode_out stays 00 5 edges, then 11 + pulse at edge 6.
// 3 locked 11, select_2 for 3 cycles then back to select_3 -> no pulse, mode_out stays 11.
// 4 all selects 0 for 7 cycles -> no fault; for 8 cycles -> fault=1, mode_valid=0, fault_seen=1.
// 5 from FAULT hold select_2 -> fault=0, mode_out=10, pulse; fault_seen=1 until fault_clr.
// 6 select_1+select_2 high mid-QUAL, then rst_n low -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/one_hot_mode_decoder.sv
// -----------------------------------------------------------------------------
// one_hot_mode_decoder
//
// Receive-side decoder for the three one-hot mode select lines. The selects
// are synchronised, each synchronised sample is checked for a legal one-hot
// pattern, and a legal code must repeat for STABLE_CYCLES samples before it is
// committed to mode_out. A run of FAULT_CYCLES illegal samples (zero-hot or
// multi-hot) raises fault. While a new code is still qualifying, consumers
// keep seeing the previous mode.
//
// Select to mode mapping:
//   select_1 -> 2'b00, select_2 -> 2'b10, select_3 -> 2'b11 (2'b01 is never produced)
//
// Ports
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   select_1     in   1  one-hot select for mode 2'b00
//   select_2     in   1  one-hot select for mode 2'b10
//   select_3     in   1  one-hot select for mode 2'b11
//   fault_clr    in   1  one-cycle pulse, clears sticky fault_seen
//   mode_out     out  2  committed mode code
//   mode_valid   out  1  mode_out holds a qualified mode
//   mode_update  out  1  one-cycle pulse when a new mode commits
//   fault        out  1  level, set on FAULT entry, cleared on the next commit
//   fault_seen   out  1  sticky, FAULT entered since last fault_clr / reset
//
// Latency: a select change that holds produces mode_update exactly
// 2 + STABLE_CYCLES rising edges later (2 synchroniser edges plus
// STABLE_CYCLES qualifying samples).
// -----------------------------------------------------------------------------
module one_hot_mode_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FAULT_CYCLES  = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       select_1,
  input  logic       select_2,
  input  logic       select_3,
  input  logic       fault_clr,
  output logic [1:0] mode_out,
  output logic       mode_valid,
  output logic       mode_update,
  output logic       fault,
  output logic       fault_seen
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] FAULT_C  = CNT_W'(FAULT_CYCLES);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Bit 0 carries select_1, bit 2 carries select_3.
  // ---------------------------------------------------------------------------
  logic [2:0] s_meta;
  logic [2:0] s;

  // NOTE: every flop, including the synchroniser, is cleared by the async
  // reset so a reset mid-qualification leaves no stale sample behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 3'b000;
      s      <= 3'b000;
    end else begin
      // NOTE: non-blocking assignments keep the two stages as separate flops;
      // a blocking assignment here would collapse the synchroniser to one.
      s_meta <= {select_3, select_2, select_1};
      s      <= s_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample validation and code decode.
  // ---------------------------------------------------------------------------
  logic       s_valid;
  logic [1:0] s_code;

  // NOTE: both outputs get a default before the case so no latch is inferred
  // for the illegal patterns.
  always_comb begin
    s_valid = 1'b0;
    s_code  = 2'b00;
    unique case (s)
      3'b001:  begin s_valid = 1'b1; s_code = 2'b00; end
      3'b010:  begin s_valid = 1'b1; s_code = 2'b10; end
      3'b100:  begin s_valid = 1'b1; s_code = 2'b11; end
      default: begin s_valid = 1'b0; s_code = 2'b00; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  state_t           state, state_next;
  logic [1:0]       cand, cand_next;
  logic [CNT_W-1:0] q_cnt, q_cnt_next;
  logic [CNT_W-1:0] inv_cnt, inv_cnt_next;

  // Control strobes from the decision logic.
  logic commit;       // publish cand_next to mode_out this edge
  logic fault_enter;  // enter FAULT this edge
  logic start_qual;   // begin qualifying the current sample's code

  // Process 1: state register plus the counters/candidate it steers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      cand    <= 2'b00;
      q_cnt   <= '0;
      inv_cnt <= '0;
    end else begin
      state   <= state_next;
      cand    <= cand_next;
      q_cnt   <= q_cnt_next;
      inv_cnt <= inv_cnt_next;
    end
  end

  // Invalid-run counter: saturates at FAULT_CYCLES, cleared by any legal sample.
  always_comb begin
    inv_cnt_next = inv_cnt;
    if (s_valid) begin
      inv_cnt_next = '0;
    end else if (inv_cnt != FAULT_C) begin
      inv_cnt_next = inv_cnt + 1'b1;
    end
  end

  // Process 2: next-state and qualification decisions.
  always_comb begin
    state_next  = state;
    cand_next   = cand;
    q_cnt_next  = q_cnt;
    commit      = 1'b0;
    fault_enter = 1'b0;
    start_qual  = 1'b0;

    if (!s_valid && (state != ST_FAULT) && (inv_cnt == FAULT_C - 1'b1)) begin
      // This invalid sample completes the run; it takes priority over the
      // QUAL fall-back to the home state.
      state_next  = ST_FAULT;
      q_cnt_next  = '0;
      fault_enter = 1'b1;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (s_valid) start_qual = 1'b1;
        end

        ST_QUAL: begin
          if (!s_valid) begin
            // Broken run: drop back to whatever consumers currently see.
            state_next = mode_valid ? ST_LOCKED : ST_INIT;
            q_cnt_next = '0;
          end else if (s_code != cand) begin
            start_qual = 1'b1;
          end else if (q_cnt == STABLE_C - 1'b1) begin
            state_next = ST_LOCKED;
            q_cnt_next = '0;
            commit     = 1'b1;
          end else begin
            q_cnt_next = q_cnt + 1'b1;
          end
        end

        ST_LOCKED: begin
          // Invalid samples only advance inv_cnt here.
          if (s_valid && (s_code != mode_out)) start_qual = 1'b1;
        end

        ST_FAULT: begin
          if (s_valid) start_qual = 1'b1;
        end

        default: begin
          state_next = ST_INIT;
          q_cnt_next = '0;
        end
      endcase

      // The first matching sample counts toward qualification, so with
      // STABLE_CYCLES == 1 it commits on the same edge and QUAL is skipped.
      if (start_qual) begin
        cand_next = s_code;
        if (STABLE_CYCLES == 1) begin
          state_next = ST_LOCKED;
          q_cnt_next = '0;
          commit     = 1'b1;
        end else begin
          state_next = ST_QUAL;
          q_cnt_next = CNT_W'(1);
        end
      end
    end
  end

  // Process 3: registered outputs driven by the decision strobes.
  logic new_mode;

  // Re-qualifying the mode already on mode_out is silent.
  always_comb begin
    new_mode = commit && (!mode_valid || (cand_next != mode_out));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_out    <= 2'b00;
      mode_valid  <= 1'b0;
      mode_update <= 1'b0;
      fault       <= 1'b0;
      fault_seen  <= 1'b0;
    end else begin
      mode_update <= new_mode;

      if (commit) begin
        mode_out   <= cand_next;
        mode_valid <= 1'b1;
        fault      <= 1'b0;
      end else if (fault_enter) begin
        // mode_out is held so the last good mode stays visible for debug.
        mode_valid <= 1'b0;
        fault      <= 1'b1;
      end

      // A FAULT entry on the same edge as fault_clr keeps the flag set.
      if (fault_enter) begin
        fault_seen <= 1'b1;
      end else if (fault_clr) begin
        fault_seen <= 1'b0;
      end
    end
  end

endmodule
